div_unit: RTL and testbench
===========================

// Module: div_unit
// PURPOSE
//  Iterative radix-2 integer divider executing RV32M DIV/DIVU/REM/REMU ops.
//  Sits in EX, downstream of the decoder: it consumes the decoder's div_inst/divsel
//  plus the forwarded rs1/rs2 values. It is multi-cycle, and busy stalls the pipeline
//  via the hazard path. One restoring step per cycle; sign fix-up on the final step.
// PARAMETERS
//  XLEN   32   operand/result width (must be >=2)
// PORTS
//  clk       in   1     system clock, all state on rising edge
//  rst       in   1     asynchronous, active-high reset
//  start     in   1     issue strobe (div_inst & ~stall), sampled in IDLE only
//  divsel    in   3     001=DIV 010=DIVU 011=REM 100=REMU; others ignored
//  op_a      in   XLEN  dividend (rs1)
//  op_b      in   XLEN  divisor (rs2)
//  kill      in   1     flush: abandon current op
//  busy      out  1     op in flight; pipeline must hold
//  done      out  1     one-cycle pulse, result valid this cycle
//  result    out  XLEN  quotient or remainder; held until next accepted start
// BEHAVIOUR
//  Reset: state=IDLE; busy=0, done=0, result=0, internal regs cleared; effect is immediate (async).
//  States: IDLE, CALC, DONE.
//  IDLE: start & valid divsel -> latch |op_a|,|op_b| (signed ops), sign flags, op kind.
//   Divisor==0 -> DONE next edge, result = all-ones (DIV/DIVU) or op_a (REM/REMU).
//   Signed op_a=min-int & op_b=-1 -> DONE, result = min-int (DIV) or 0 (REM).
//   Otherwise -> CALC with count=XLEN; busy=1 from the cycle after the start edge.
//   Invalid divsel or start with kill high -> stay IDLE, no done.
//  CALC: each cycle shift {rem,quo} left 1, trial-subtract divisor, set quo LSB.
//   count decrements; when count reaches 1, the step result is sign-corrected
//   (quo negated if signs differ; rem takes the dividend's sign) and registered into result -> DONE.
//   Normal latency: start edge t, done high in cycle t+XLEN+1 (t+33 for XLEN=32).
//   Special-case latency: done in cycle t+1.
//  DONE: done=1, busy=0 for exactly one cycle -> IDLE. A start in DONE is ignored
//   (the decoder cannot issue the next op before IDLE).
//  start while busy: ignored, no state change.
//  kill in CALC or DONE: next edge -> IDLE, done forced 0, result keeps its old value.
//   kill takes priority over completion on the same edge.
//  Widths: operands zero-extended to XLEN+1 internally for trial subtraction;
//   absolute value of min-int stays representable as unsigned XLEN.
//  busy is registered (no combinational path from start).
// STRUCTURE
//  riscv_pkg: localparams DIVSEL_DIV/DIVU/REM/REMU, typedef enum div_state_t
//   {IDLE,CALC,DONE}. Shared with the decoder and hazard unit.
//  Sub-module div_step: combinational single restoring iteration
//   (rem_in, quo_in, divisor -> rem_out, quo_out).
//  Top holds the FSM, counter ($clog2(XLEN)+1 bits), operand regs and sign fix-up.
// TESTING
//  DIVU 100/7 -> done at t+33, result=14; REMU 100/7 -> 2.
//  DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIV 7/-2 -> 0xFFFFFFFD.
//  DIVU 5/0 -> 0xFFFFFFFF at t+1; REM 5/0 -> 5 at t+1.
//  DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM -> 0; both at t+1.
//  kill at t+10 of DIVU -> no done, busy=0 next cycle; new DIVU 9/3 then gives 3.
//  start pulses while busy, and rst asserted mid-CALC -> ignored/immediate IDLE, outputs 0.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32M divider definitions: divsel encodings and divider FSM states.
// Imported by the decoder, hazard unit and divider.
package riscv_pkg;

  localparam logic [2:0] DIVSEL_DIV  = 3'b001;
  localparam logic [2:0] DIVSEL_DIVU = 3'b010;
  localparam logic [2:0] DIVSEL_REM  = 3'b011;
  localparam logic [2:0] DIVSEL_REMU = 3'b100;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_t;

endpackage

// File: rtl/div_unit_if.sv
// Issue/complete bundle between the EX stage and the iterative divider.
// master = pipeline side, slave = divider.
interface div_unit_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [2:0]      divsel;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic            kill;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (
    output start, divsel, op_a, op_b, kill,
    input  busy, done, result
  );

  modport slave (
    input  start, divsel, op_a, op_b, kill,
    output busy, done, result
  );
endinterface

// File: rtl/div_step.sv
// One restoring division iteration: shift {rem,quo} left, trial-subtract,
// keep the difference and set the quotient bit when it does not go negative.
module div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem_in,
  input  logic [XLEN-1:0] quo_in,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] rem_out,
  output logic [XLEN-1:0] quo_out
);
  logic [XLEN:0] rem_sh;
  logic [XLEN:0] trial;
  logic          ge;

  // rem < divisor keeps |trial| below 2^XLEN, so bit XLEN is its sign
  always_comb begin
    rem_sh  = {rem_in, quo_in[XLEN-1]};
    trial   = rem_sh - {1'b0, divisor};
    ge      = ~trial[XLEN];
    rem_out = ge ? trial[XLEN-1:0] : rem_sh[XLEN-1:0];
    quo_out = {quo_in[XLEN-2:0], ge};
  end
endmodule

// File: rtl/div_unit.sv
// Iterative radix-2 RV32M divider (DIV/DIVU/REM/REMU) in EX.
// One restoring step per cycle; divide-by-zero and overflow finish at once.
module div_unit
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic       clk,
  input  logic       rst,
  div_unit_if.slave  dif
);
  localparam int CW = $clog2(XLEN) + 1;

  div_state_t state, state_n;

  logic [CW-1:0]   count;
  logic [XLEN-1:0] rem_q, quo_q, dvs_q, result_q;
  logic            qneg_q, rneg_q, is_rem_q;
  logic [XLEN-1:0] rem_s, quo_s;

  logic            sel_ok, sel_sgn, sel_rem;
  logic            a_neg, b_neg, b_zero, ovf;
  logic            accept, special, last;
  logic [XLEN-1:0] abs_a, abs_b, min_int;
  logic [XLEN-1:0] special_res, qfix, rfix;

  div_step #(
    .XLEN(XLEN)
  ) u_step (
    .rem_in (rem_q),
    .quo_in (quo_q),
    .divisor(dvs_q),
    .rem_out(rem_s),
    .quo_out(quo_s)
  );

  always_comb begin
    sel_ok  = 1'b1;
    sel_sgn = 1'b0;
    sel_rem = 1'b0;
    case (dif.divsel)
      DIVSEL_DIV:  sel_sgn = 1'b1;
      DIVSEL_DIVU: sel_sgn = 1'b0;
      DIVSEL_REM: begin
        sel_sgn = 1'b1;
        sel_rem = 1'b1;
      end
      DIVSEL_REMU: sel_rem = 1'b1;
      default:     sel_ok  = 1'b0;
    endcase
  end

  always_comb begin
    min_int = {1'b1, {(XLEN-1){1'b0}}};
    a_neg   = sel_sgn & dif.op_a[XLEN-1];
    b_neg   = sel_sgn & dif.op_b[XLEN-1];
    abs_a   = a_neg ? -dif.op_a : dif.op_a;
    abs_b   = b_neg ? -dif.op_b : dif.op_b;
    b_zero  = (dif.op_b == '0);
    ovf     = sel_sgn & (dif.op_a == min_int)
            & (dif.op_b == '1);
    special = b_zero | ovf;
    accept  = (state == IDLE) & dif.start
            & sel_ok & ~dif.kill;
    last    = (count == CW'(1));
    if (b_zero)
      special_res = sel_rem ? dif.op_a : '1;
    else
      special_res = sel_rem ? '0 : min_int;
    qfix = qneg_q ? -quo_s : quo_s;
    rfix = rneg_q ? -rem_s : rem_s;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (accept) state_n = special ? DONE : CALC;
      CALC: begin
        if (dif.kill)  state_n = IDLE;
        else if (last) state_n = DONE;
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      is_rem_q <= 1'b0;
      result_q <= '0;
    end else if (accept) begin
      count    <= CW'(XLEN);
      rem_q    <= '0;
      quo_q    <= abs_a;
      dvs_q    <= abs_b;
      qneg_q   <= a_neg ^ b_neg;
      rneg_q   <= a_neg;
      is_rem_q <= sel_rem;
      if (special) result_q <= special_res;
    end else if (state == CALC && !dif.kill) begin
      rem_q <= rem_s;
      quo_q <= quo_s;
      count <= count - CW'(1);
      if (last) result_q <= is_rem_q ? rfix : qfix;
    end
  end

  // a flush in DONE must also suppress the writeback pulse
  assign dif.busy   = (state == CALC);
  assign dif.done   = (state == DONE) & ~dif.kill;
  assign dif.result = result_q;
endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed RV32M cases plus random ops
// against an arithmetic reference model.
module tb_div_unit;
  localparam int XLEN = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  div_unit_if #(.XLEN(XLEN)) dif ();

  div_unit #(.XLEN(XLEN)) dut (
    .clk(clk),
    .rst(rst),
    .dif(dif)
  );

  int checks = 0;
  int errors = 0;
  logic [31:0] last_res = '0;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_div(input logic [2:0] sel,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
    longint sa, sb, ua, ub, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'(a);
    ub = longint'(b);
    r  = 0;
    case (sel)
      3'b001: r = (b == 0) ? -1 : sa / sb;
      3'b010: r = (b == 0) ? 64'hFFFF_FFFF : ua / ub;
      3'b011: r = (b == 0) ? sa : sa % sb;
      3'b100: r = (b == 0) ? ua : ua % ub;
      default: r = 0;
    endcase
    return r[31:0];
  endfunction

  function automatic int ref_lat(input logic [2:0] sel,
                                 input logic [31:0] a,
                                 input logic [31:0] b);
    bit sgn;
    sgn = (sel == 3'b001) || (sel == 3'b011);
    if (b == 0) return 1;
    if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return XLEN + 1;
  endfunction

  // called at posedge+1; returns at posedge+1 after the start edge
  task automatic start_op(input logic [2:0] sel,
                          input logic [31:0] a,
                          input logic [31:0] b);
    dif.start  = 1'b1;
    dif.divsel = sel;
    dif.op_a   = a;
    dif.op_b   = b;
    @(posedge clk); #1;
    dif.start  = 1'b0;
  endtask

  task automatic wait_done(input string tag,
                           input logic [31:0] exp,
                           input int lat,
                           input int n0);
    int n;
    n = n0;
    while (dif.done !== 1'b1 && n < 80) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_done"}, 32'(dif.done), 32'd1);
    check({tag, "_lat"}, 32'(n), 32'(lat));
    check({tag, "_res"}, dif.result, exp);
    last_res = exp;
  endtask

  task automatic run_op(input string tag,
                        input logic [2:0] sel,
                        input logic [31:0] a,
                        input logic [31:0] b);
    int lat;
    lat = ref_lat(sel, a, b);
    start_op(sel, a, b);
    check({tag, "_busy"}, 32'(dif.busy), 32'(lat != 1));
    wait_done(tag, ref_div(sel, a, b), lat, 1);
    @(posedge clk); #1;
    check({tag, "_idle"}, 32'({dif.busy, dif.done}), 32'd0);
  endtask

  initial begin
    int seen;
    logic [2:0] sel;
    logic [31:0] a, b;
    dif.start  = 1'b0;
    dif.divsel = 3'b000;
    dif.op_a   = '0;
    dif.op_b   = '0;
    dif.kill   = 1'b0;
    #1;
    check("rst_busy", 32'(dif.busy), 32'd0);
    check("rst_done", 32'(dif.done), 32'd0);
    check("rst_result", dif.result, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    run_op("divu_100_7", 3'b010, 32'd100, 32'd7);
    check("divu_100_7_val", last_res, 32'd14);

    // start during DONE is ignored
    start_op(3'b010, 32'd100, 32'd7);
    wait_done("divu_again", 32'd14, XLEN + 1, 1);
    start_op(3'b010, 32'd50, 32'd5);
    check("start_in_done", 32'({dif.busy, dif.done}), 32'd0);
    check("start_in_done_res", dif.result, 32'd14);
    @(posedge clk); #1;

    run_op("remu_100_7", 3'b100, 32'd100, 32'd7);
    check("remu_val", last_res, 32'd2);
    run_op("div_m7_2", 3'b001, 32'hFFFF_FFF9, 32'd2);
    check("div_m7_2_val", last_res, 32'hFFFF_FFFD);
    run_op("rem_m7_2", 3'b011, 32'hFFFF_FFF9, 32'd2);
    check("rem_m7_2_val", last_res, 32'hFFFF_FFFF);
    run_op("div_7_m2", 3'b001, 32'd7, 32'hFFFF_FFFE);
    check("div_7_m2_val", last_res, 32'hFFFF_FFFD);
    run_op("divu_5_0", 3'b010, 32'd5, 32'd0);
    check("divu_5_0_val", last_res, 32'hFFFF_FFFF);
    run_op("rem_5_0", 3'b011, 32'd5, 32'd0);
    check("rem_5_0_val", last_res, 32'd5);
    run_op("div_ovf", 3'b001, 32'h8000_0000, 32'hFFFF_FFFF);
    check("div_ovf_val", last_res, 32'h8000_0000);
    run_op("rem_ovf", 3'b011, 32'h8000_0000, 32'hFFFF_FFFF);
    check("rem_ovf_val", last_res, 32'd0);

    // kill mid-CALC
    start_op(3'b010, 32'd1000, 32'd3);
    repeat (9) @(posedge clk);
    #1 dif.kill = 1'b1;
    @(posedge clk); #1;
    dif.kill = 1'b0;
    check("kill_idle", 32'({dif.busy, dif.done}), 32'd0);
    check("kill_res_held", dif.result, last_res);
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (dif.done === 1'b1) seen++;
    end
    check("kill_no_done", 32'(seen), 32'd0);
    run_op("divu_9_3", 3'b010, 32'd9, 32'd3);
    check("divu_9_3_val", last_res, 32'd3);

    // start while busy is ignored
    start_op(3'b001, 32'hFFFF_FF00, 32'd10);
    repeat (5) @(posedge clk);
    #1;
    start_op(3'b010, 32'd77, 32'd7);
    wait_done("busy_start", ref_div(3'b001, 32'hFFFF_FF00, 32'd10),
              XLEN + 1, 7);
    @(posedge clk); #1;

    // invalid divsel and start with kill
    dif.kill = 1'b1;
    start_op(3'b010, 32'd8, 32'd2);
    dif.kill = 1'b0;
    check("start_kill", 32'({dif.busy, dif.done}), 32'd0);
    start_op(3'b111, 32'd8, 32'd2);
    check("bad_sel", 32'({dif.busy, dif.done}), 32'd0);
    seen = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (dif.done === 1'b1) seen++;
    end
    check("bad_sel_no_done", 32'(seen), 32'd0);

    // async reset mid-CALC
    start_op(3'b010, 32'd500, 32'd9);
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("rst_mid_busy", 32'(dif.busy), 32'd0);
    check("rst_mid_done", 32'(dif.done), 32'd0);
    check("rst_mid_res", dif.result, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 30; i++) begin
      sel = 3'($urandom_range(1, 4));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = '0;
        1: b = '1;
        2: a = 32'h8000_0000;
        3: b = 32'($urandom_range(1, 20));
        default: ;
      endcase
      run_op($sformatf("rnd%0d", i), sel, a, b);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
